// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_CHECK  = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_t;

    localparam int BYTES_PER_WORD  = 4;
    localparam int WORD_BYTES_LOG2 = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs an accepted byte stream little-endian into 32-bit words.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        arst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_done,
    output logic [31:0] word
);

    localparam logic [WORD_BYTES_LOG2-1:0] LAST_LANE = WORD_BYTES_LOG2'(BYTES_PER_WORD - 1);

    logic [WORD_BYTES_LOG2-1:0] lane_r;
    logic [31:0]                lanes_r;
    logic [31:0]                merged_s;

    // Word as it looks with the incoming byte dropped into its lane.
    always_comb begin
        merged_s = lanes_r;
        case (lane_r)
            2'd0:    merged_s[7:0]   = byte_data;
            2'd1:    merged_s[15:8]  = byte_data;
            2'd2:    merged_s[23:16] = byte_data;
            2'd3:    merged_s[31:24] = byte_data;
            default: merged_s        = lanes_r;
        endcase
    end

    assign word_done = byte_valid & (lane_r == LAST_LANE);
    assign word      = merged_s;

    // Lane counter and partial-word register; a completed word restarts at lane 0.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            lane_r  <= '0;
            lanes_r <= 32'h0;
        end else if (clear) begin
            lane_r  <= '0;
            lanes_r <= 32'h0;
        end else if (byte_valid) begin
            lane_r  <= lane_r + 2'd1;
            lanes_r <= word_done ? 32'h0 : merged_s;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte image into instruction memory, then holds the CPU enabled.
// Optional readback checksum check is compiled in with IMEM_LOADER_VERIFY_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W    = 9,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            start,
    input  logic [ADDR_W:0] word_count,
    input  logic            abort,
    input  logic            s_valid,
    input  logic [7:0]      s_data,
    output logic            s_ready,
    output logic [63:0]     addr_ext,
    output logic            wen_ext,
    output logic            ren_ext,
    output logic [31:0]     wdata_ext,
    input  logic [31:0]     rdata_ext,
    output logic            cpu_enable,
    output logic            busy,
    output logic            error
);

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_t   state_r;
    logic [ADDR_W:0] count_r;
    logic [ADDR_W:0] word_idx_r;
    logic [ADDR_W:0] word_idx_nxt_s;
    logic            byte_fire_s;
    logic            clear_s;
    logic            count_bad_s;
    logic            word_done_s;
    logic [31:0]     word_s;

`ifdef IMEM_LOADER_VERIFY_EN
    logic [ADDR_W:0] rd_idx_r;
    logic [31:0]     csum_r;
    logic [31:0]     rsum_r;
    logic [31:0]     rsum_nxt_s;
    logic            rvalid_r;
`else
    logic            unused_rdata_s;
    assign unused_rdata_s = ^rdata_ext;
    assign ren_ext        = 1'b0;
`endif

    function automatic logic [63:0] word_addr(input logic [ADDR_W:0] idx);
        logic [63:0] off_s;
        off_s = 64'(idx) << WORD_BYTES_LOG2;
        return BASE_ADDR + off_s;
    endfunction

    // Abort wins over a simultaneous handshake, so that byte never reaches the packer.
    assign byte_fire_s    = s_valid & s_ready & ~abort & (state_r == ST_LOAD);
    assign clear_s        = abort | (start & (state_r == ST_IDLE));
    assign count_bad_s    = (word_count == '0) || (word_count > MAX_WORDS);
    assign word_idx_nxt_s = word_idx_r + IDX_ONE;

    byte_packer u_packer (
        .clk        (clk),
        .arst_n     (arst_n),
        .clear      (clear_s),
        .byte_valid (byte_fire_s),
        .byte_data  (s_data),
        .word_done  (word_done_s),
        .word       (word_s)
    );

`ifdef IMEM_LOADER_VERIFY_EN
    // Readback data arrives one cycle after its strobe.
    always_comb begin
        if (rvalid_r) begin
            rsum_nxt_s = rsum_r + rdata_ext;
        end else begin
            rsum_nxt_s = rsum_r;
        end
    end
`endif

    // Loader FSM; every output is a register written on the transition into its state.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r    <= ST_IDLE;
            count_r    <= '0;
            word_idx_r <= '0;
            s_ready    <= 1'b0;
            addr_ext   <= 64'h0;
            wen_ext    <= 1'b0;
            wdata_ext  <= 32'h0;
            cpu_enable <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
            ren_ext    <= 1'b0;
            rd_idx_r   <= '0;
            csum_r     <= 32'h0;
            rsum_r     <= 32'h0;
            rvalid_r   <= 1'b0;
`endif
        end else if (abort) begin
            state_r    <= ST_IDLE;
            s_ready    <= 1'b0;
            addr_ext   <= 64'h0;
            wen_ext    <= 1'b0;
            wdata_ext  <= 32'h0;
            cpu_enable <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
            ren_ext    <= 1'b0;
            rvalid_r   <= 1'b0;
`endif
        end else begin
`ifdef IMEM_LOADER_VERIFY_EN
            rvalid_r <= ren_ext;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (count_bad_s) begin
                            state_r <= ST_ERROR;
                            error   <= 1'b1;
                        end else begin
                            state_r    <= ST_LOAD;
                            count_r    <= word_count;
                            word_idx_r <= '0;
                            s_ready    <= 1'b1;
                            busy       <= 1'b1;
`ifdef IMEM_LOADER_VERIFY_EN
                            csum_r     <= 32'h0;
`endif
                        end
                    end
                end
                ST_LOAD: begin
                    if (word_done_s) begin
                        state_r   <= ST_WRITE;
                        s_ready   <= 1'b0;
                        wen_ext   <= 1'b1;
                        addr_ext  <= word_addr(word_idx_r);
                        wdata_ext <= word_s;
                    end
                end
                ST_WRITE: begin
                    wen_ext    <= 1'b0;
                    addr_ext   <= 64'h0;
                    wdata_ext  <= 32'h0;
                    word_idx_r <= word_idx_nxt_s;
`ifdef IMEM_LOADER_VERIFY_EN
                    csum_r     <= csum_r + wdata_ext;
`endif
                    if (word_idx_nxt_s == count_r) begin
`ifdef IMEM_LOADER_VERIFY_EN
                        state_r  <= ST_VERIFY;
                        ren_ext  <= 1'b1;
                        addr_ext <= word_addr('0);
                        rd_idx_r <= IDX_ONE;
                        rsum_r   <= 32'h0;
`else
                        state_r    <= ST_RUN;
                        cpu_enable <= 1'b1;
                        busy       <= 1'b0;
`endif
                    end else begin
                        state_r <= ST_LOAD;
                        s_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_VERIFY_EN
                ST_VERIFY: begin
                    rsum_r <= rsum_nxt_s;
                    // rd_idx_r is the next read to issue; reaching the count means the last one is on the bus.
                    if (rd_idx_r == count_r) begin
                        state_r  <= ST_CHECK;
                        ren_ext  <= 1'b0;
                        addr_ext <= 64'h0;
                    end else begin
                        addr_ext <= word_addr(rd_idx_r);
                        rd_idx_r <= rd_idx_r + IDX_ONE;
                    end
                end
                ST_CHECK: begin
                    rsum_r <= rsum_nxt_s;
                    busy   <= 1'b0;
                    if (rsum_nxt_s == csum_r) begin
                        state_r    <= ST_RUN;
                        cpu_enable <= 1'b1;
                    end else begin
                        state_r <= ST_ERROR;
                        error   <= 1'b1;
                    end
                end
`endif
                ST_RUN: begin
                    cpu_enable <= 1'b1;
                end
                ST_ERROR: begin
                    error <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    s_ready    <= 1'b0;
                    addr_ext   <= 64'h0;
                    wen_ext    <= 1'b0;
                    wdata_ext  <= 32'h0;
                    cpu_enable <= 1'b0;
                    busy       <= 1'b0;
                    error      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Host-side initiator for the CPU's external instruction-memory port. Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instruction words, and writes them sequentially into instruction memory via the `addr_ext`/`wen_ext`/`wdata_ext` path. It can optionally read the image back and check it. It then holds the CPU `enable` high until aborted. It sits between a host link (UART/JTAG bridge) and the `cpu` top.

## Interface

**Parameters**
- `ADDR_W`, default 9: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `BASE_ADDR`, default 64'h0: byte address of the first word written.

**Ports**
- `clk` in 1: single clock; all logic on rising edge.
- `arst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse; begins a load. Sampled only in IDLE.
- `word_count` in ADDR_W+1: number of words to load. Sampled together with `start`.
- `abort` in 1: returns the block to IDLE from any state. Has priority over every other input.
- `s_valid` in 1: byte-stream valid.
- `s_data` in 8: byte-stream data.
- `s_ready` out 1: byte accepted on cycles where `s_valid & s_ready`.
- `addr_ext` out 64: byte address to instruction memory.
- `wen_ext` out 1: instruction-memory write strobe.
- `ren_ext` out 1: instruction-memory read strobe.
- `wdata_ext` out 32: write word.
- `rdata_ext` in 32: read word; valid one cycle after `ren_ext`.
- `cpu_enable` out 1: drives the CPU `enable` input.
- `busy` out 1: high in LOAD, WRITE, VERIFY and CHECK.
- `error` out 1: high in ERROR.

## Operation

**States:** IDLE, LOAD, WRITE, VERIFY, CHECK, RUN, ERROR.

**IDLE**
- On `start`:
  - If `word_count == 0` or `word_count > 2^ADDR_W`, go to ERROR.
  - Otherwise latch the count, clear the byte index, word index and checksum, and go to LOAD.

**LOAD**
- `s_ready = 1`.
- Each accepted byte goes into lane `byte_idx` (byte 0 = bits [7:0]).
- When the 4th byte is accepted, go to WRITE.

**WRITE** (exactly one cycle)
- `wen_ext = 1`, `addr_ext = BASE_ADDR + 4*word_idx`, `wdata_ext` = packed word, `s_ready = 0`.
- Checksum update: `csum += word`, modulo 2^32.
- Increment `word_idx`.
- If this was the last word, go to VERIFY when the macro is defined, or to RUN when it is not.
- Otherwise return to LOAD.

**VERIFY**
- Issue one read per cycle: `ren_ext = 1`, `addr_ext = BASE_ADDR + 4*rd_idx`, for `rd_idx` = 0 … N-1.
- Each returned word is added into `rsum` one cycle later.
- After the last read is issued, go to CHECK.

**CHECK** (one cycle)
- Accumulate the final returned word.
- If `rsum == csum`, go to RUN; otherwise go to ERROR.

**RUN**
- `cpu_enable = 1`. The block stays in RUN until `abort`.

**ERROR**
- `error = 1`. The block is sticky until `abort`.

**General rules**
- `start` outside IDLE is ignored.
- `abort` in any state discards any partial word, deasserts all strobes and `cpu_enable`, and goes to IDLE on the next edge.
- `abort` on the same cycle as a byte handshake: the byte is dropped.
- `addr_ext` for word index i = `BASE_ADDR + {i, 2'b00}`. No wrap: the bound check at start guarantees i < 2^ADDR_W.
- `wen_ext` and `ren_ext` are never high on the same cycle.

## Timing

- **Reset values:** all outputs 0, state IDLE; `addr_ext` and `wdata_ext` are 0.
- **Byte to write:** `wen_ext` rises the cycle after the 4th-byte handshake.
- **Sustained rate:** 4 bytes per 5 cycles.
- **`start` to `s_ready`:** `s_ready` first goes high 1 cycle after `start`.
- **Load phase (N words, `s_valid` held high):** the last `wen_ext` falls at cycle 5N after entering LOAD.
- **Verify phase:** N cycles of VERIFY plus 1 cycle of CHECK.
- **RUN entry:** `cpu_enable` rises on entry to RUN, and all outputs are registered.
- **Reset mid-operation:** everything is cleared asynchronously and no write is completed. Memory contents are untouched apart from writes already issued.

## Configuration

- **`IMEM_LOADER_VERIFY_EN` defined:** the VERIFY and CHECK states, `rsum` and the checksum compare are compiled in.
- **`IMEM_LOADER_VERIFY_EN` undefined:**
  - `ren_ext` is tied to 0 and `rdata_ext` is unused.
  - The last WRITE goes directly to RUN, so ERROR is reachable only through the `word_count` check.

## Structure

- **Shared package `imem_loader_pkg`:**
  - state enum `loader_state_t`
  - `BYTES_PER_WORD = 4`
  - `WORD_BYTES_LOG2 = 2`
- **One sub-module, `byte_packer`:** a 2-bit lane counter plus a 32-bit shift/lane register. It exposes `word_done` and `word` and is cleared by `abort`.

## Test plan

1. **Basic load:** `word_count = 2`, bytes 13 00 00 00 93 00 10 00.
   - Writes 0x00000013 @ 0x0 and 0x00100093 @ 0x4.
   - `cpu_enable = 1` (with verify enabled, after 2 reads and a matching checksum).
2. **Invalid counts:**
   - `word_count = 0` → `error = 1` one cycle after `start`, and no `wen_ext`.
   - `word_count = 513` with `ADDR_W = 9` → same.
3. **Stalled stream:** `s_valid` toggles every other cycle.
   - Exactly one `wen_ext` per 4 accepted bytes.
   - `wdata_ext` is correct and addresses are 0x0, 0x4, 0x8.
4. **Verify mismatch** (macro on): the memory model corrupts word 1 on readback.
   - CHECK → ERROR, `cpu_enable` stays 0.
   - `abort` → IDLE, `error = 0`.
5. **Abort mid-word:** `abort` after 2 bytes of word 0.
   - No `wen_ext`, block in IDLE.
   - A new `start` loads cleanly from address `BASE_ADDR`.
6. **Async reset in WRITE:** `arst_n` low during the `wen_ext` cycle.
   - All outputs are 0 immediately and the state is IDLE after reset is released.
